// File: rtl/stoch_to_binary.sv
// Stochastic-bitstream to binary converter: counts the ones among a window of
// window_len qualified stream bits and reports the total with a one-cycle done.
module stoch_to_binary #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] window_len,
  input  logic             bit_in,
  input  logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] value
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ACCUM = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] len_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] ones_q;
  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] ones_next;
  logic             last_bit;

  // The ones count is bounded by len_q, so this add can never wrap.
  assign ones_next = ones_q + WIDTH'(bit_in);
  assign last_bit  = (cnt_q == len_q - WIDTH'(1));

  assign busy  = (state == ACCUM);
  assign done  = (state == DONE);
  assign value = value_q;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      ones_q  <= '0;
      value_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (window_len != '0) begin
              len_q  <= window_len;
              cnt_q  <= '0;
              ones_q <= '0;
              state  <= ACCUM;
            end else begin
              value_q <= '0;
              state   <= DONE;
            end
          end
        end
        ACCUM: begin
          if (bit_valid) begin
            cnt_q  <= cnt_q + WIDTH'(1);
            ones_q <= ones_next;
            if (last_bit) begin
              value_q <= ones_next;
              state   <= DONE;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stoch_to_binary.sv
// Randomized self-checking bench for stoch_to_binary; expected results come
// from counting ones in the stimulus array of each window.
module tb_stoch_to_binary;

  localparam int W = 9;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] window_len;
  logic         bit_in;
  logic         bit_valid;
  logic         busy;
  logic         done;
  logic [W-1:0] value;

  int checks     = 0;
  int failures   = 0;
  int last_value = 0;

  bit stim_bits [512];
  int stim_gap  [512];

  always #5 clk = ~clk;

  stoch_to_binary #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .window_len (window_len),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .busy       (busy),
    .done       (done),
    .value      (value)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < 512; i++) begin
      stim_bits[i] = 1'b0;
      stim_gap[i]  = 0;
    end
  endtask

  // Idle cycles with noise on the stream inputs; outputs must stay quiet.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_busy", busy, 0);
      check("idle_done", done, 0);
      check("idle_value", value, last_value);
      start     = 1'b0;
      bit_valid = 1'($urandom);
      bit_in    = 1'($urandom);
    end
    @(negedge clk);
    bit_valid = 1'b0;
  endtask

  task automatic accum_cycle_checks();
    check("acc_busy", busy, 1);
    check("acc_done", done, 0);
    check("acc_hold", value, last_value);
    start      = ($urandom_range(0, 3) == 0);
    window_len = W'($urandom);
  endtask

  task automatic run_window(input int len);
    int ones = 0;
    for (int i = 0; i < len; i++) ones += int'(stim_bits[i]);
    @(negedge clk);
    start      = 1'b1;
    window_len = W'(len);
    bit_valid  = 1'($urandom);
    bit_in     = 1'($urandom);
    @(posedge clk); #1;
    if (len == 0) begin
      check("zw_done", done, 1);
      check("zw_value", value, 0);
      check("zw_busy", busy, 0);
      last_value = 0;
    end else begin
      for (int i = 0; i < len; i++) begin
        for (int g = 0; g < stim_gap[i]; g++) begin
          @(negedge clk);
          accum_cycle_checks();
          bit_valid = 1'b0;
          bit_in    = 1'($urandom);
          @(posedge clk);
        end
        @(negedge clk);
        accum_cycle_checks();
        bit_valid = 1'b1;
        bit_in    = stim_bits[i];
        @(posedge clk);
      end
      #1;
      check("win_done", done, 1);
      check("win_value", value, ones);
      check("win_busy", busy, 0);
      last_value = ones;
    end
    // start during the done cycle must not begin a new window
    @(negedge clk);
    start      = 1'b1;
    window_len = W'($urandom_range(1, 20));
    bit_valid  = 1'b1;
    bit_in     = 1'b1;
    @(posedge clk); #1;
    check("post_done", done, 0);
    check("post_busy", busy, 0);
    check("post_value", value, last_value);
    @(negedge clk);
    start     = 1'b0;
    bit_valid = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    window_len = '0;
    bit_in     = 1'b0;
    bit_valid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_value", value, 0);
    @(negedge clk);
    rst = 1'b0;
    idle_cycles(3);

    // Full window, pattern 1,0,1,1,0,0,1,0
    clear_stim();
    begin
      bit pat [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) stim_bits[i] = pat[i];
    end
    run_window(8);
    check("full_value", value, 4);
    idle_cycles(2);

    // Gapped valid: four ones with three idle cycles interleaved
    clear_stim();
    for (int i = 0; i < 4; i++) stim_bits[i] = 1'b1;
    for (int i = 1; i < 4; i++) stim_gap[i] = 1;
    run_window(4);
    idle_cycles(2);

    // Zero-length window
    run_window(0);
    idle_cycles(2);

    // Shortest non-empty window
    clear_stim();
    stim_bits[0] = 1'b1;
    run_window(1);
    idle_cycles(1);

    // Maximum window, all ones
    clear_stim();
    for (int i = 0; i < 511; i++) stim_bits[i] = 1'b1;
    run_window(511);
    check("max_value", value, 511);
    idle_cycles(2);

    // Reset after 3 of 8 bits, with start and bit_valid also asserted
    clear_stim();
    @(negedge clk);
    start      = 1'b1;
    window_len = W'(8);
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      accum_cycle_checks();
      bit_valid = 1'b1;
      bit_in    = 1'b1;
      @(posedge clk);
    end
    @(negedge clk);
    rst       = 1'b1;
    start     = 1'b1;
    bit_valid = 1'b1;
    bit_in    = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_value", value, 0);
    last_value = 0;
    @(negedge clk);
    rst       = 1'b0;
    start     = 1'b0;
    bit_valid = 1'b0;
    idle_cycles(10);

    // Randomized windows with random gaps and spurious start pulses
    for (int n = 0; n < 25; n++) begin
      int len;
      clear_stim();
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        stim_bits[i] = 1'($urandom);
        stim_gap[i]  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
      end
      if (n % 8 == 7) run_window(0);
      else            run_window(len);
      idle_cycles($urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
